pcd8544_sprite_seq: RTL and testbench

Parametrised command/data sequencer for the PCD8544 (84×48, 6 banks) LCD. It sits between the game/display logic and `spi_master`. After reset it runs the controller init sequence and a full-screen clear. It then serves draw requests that blit, erase or invert-blit a sprite from an external sprite ROM at any column/bank. Sprites are clipped at the panel edge. The block drives `spi_master`'s byte interface (`data_in`/`command`/`start`/`avail`); it does not instantiate it.

---
 rtl/pcd8544_sprite_seq_if.sv | 38 +++
 rtl/pcd8544_sprite_seq.sv | 276 +++++++++++++++++++++++++++
 tb/tb_pcd8544_sprite_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/pcd8544_sprite_seq_if.sv
`default_nettype none
// ------------------------------------------------------------------
// pcd8544_sprite_seq_if : draw request, sprite ROM and spi_master bundle
// Rev 1.0
// ------------------------------------------------------------------
interface pcd8544_sprite_seq_if #(
  parameter int SEL_W  = 2,
  parameter int ROM_AW = 8
) ();
  logic              draw_req;
  logic [6:0]        draw_x;
  logic [2:0]        draw_bank;
  logic [SEL_W-1:0]  draw_sel;
  logic [1:0]        draw_mode;
  logic [ROM_AW-1:0] rom_addr;
  logic [7:0]        rom_data;
  logic [7:0]        tx_data;
  logic              tx_dc;
  logic              tx_start;
  logic              tx_avail;
  logic              ready;
  logic              done;
  logic              err;
  logic              back;

  // master: the sequencer itself
  modport master (
    input  draw_req, draw_x, draw_bank, draw_sel, draw_mode, rom_data, tx_avail,
    output rom_addr, tx_data, tx_dc, tx_start, ready, done, err, back
  );

  // slave: game logic, sprite ROM and spi_master around the sequencer
  modport slave (
    output draw_req, draw_x, draw_bank, draw_sel, draw_mode, rom_data, tx_avail,
    input  rom_addr, tx_data, tx_dc, tx_start, ready, done, err, back
  );
endinterface
`default_nettype wire

// File: rtl/pcd8544_sprite_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// pcd8544_sprite_seq : PCD8544 init/clear plus clipped sprite blitter
// Rev 1.0
// ------------------------------------------------------------------
module pcd8544_sprite_seq #(
  parameter int         SPRITE_W     = 16,
  parameter int         SPRITE_PAGES = 2,
  parameter int         SPRITE_COUNT = 4,
  parameter int         ROM_AW       = 8,
  parameter logic [6:0] CONTRAST     = 7'h10
) (
  input  wire logic            clock,
  input  wire logic            Reset,
  pcd8544_sprite_seq_if.master bus
);
  localparam int         SEL_W   = (SPRITE_COUNT > 1) ? $clog2(SPRITE_COUNT) : 1;
  localparam logic [7:0] W8      = 8'(SPRITE_W);
  localparam logic [3:0] PAGES4  = 4'(SPRITE_PAGES);
  localparam int         SPR_SZ  = SPRITE_W * SPRITE_PAGES;

  typedef enum logic [3:0] {
    S_INIT_CMD  = 4'd0,
    S_CLR_SETX  = 4'd1,
    S_CLR_SETY  = 4'd2,
    S_CLR_DATA  = 4'd3,
    S_IDLE      = 4'd4,
    S_DRW_SETX  = 4'd5,
    S_DRW_SETY  = 4'd6,
    S_DRW_FETCH = 4'd7,
    S_DRW_DATA  = 4'd8,
    S_DONE      = 4'd9
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         init_idx_q, init_idx_d;
  logic [8:0]         clr_cnt_q, clr_cnt_d;
  logic [2:0]         page_q, page_d;
  logic [7:0]         col_q, col_d;
  logic [6:0]         x_q, x_d;
  logic [2:0]         bank_q, bank_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [1:0]         mode_q, mode_d;
  logic               loaded_q, loaded_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               tx_dc_q, tx_dc_d;
  logic               tx_start_q, tx_start_d;
  logic [ROM_AW-1:0]  rom_addr_q, rom_addr_d;
  logic               ready_q, ready_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               back_q, back_d;

  logic [3:0] w_page_nxt;
  logic [3:0] w_bank_cur;
  logic [3:0] w_bank_nxt;
  logic       w_page_ok;
  logic [7:0] w_col_nxt;
  logic [7:0] w_xc_nxt;
  logic       w_col_ok;
  logic [7:0] w_byte;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return 8'h21;
      2'd1:    return {1'b1, CONTRAST};
      2'd2:    return 8'h20;
      default: return 8'h0C;
    endcase
  endfunction

  function automatic logic [ROM_AW-1:0] addr_of(input logic [SEL_W-1:0] sel,
                                                input logic [2:0] p,
                                                input logic [7:0] c);
    logic [31:0] a;
    a = 32'(sel) * 32'(SPR_SZ) + 32'(p) * 32'(SPRITE_W) + 32'(c);
    return ROM_AW'(a);
  endfunction

  assign w_page_nxt = {1'b0, page_q} + 4'd1;
  assign w_bank_cur = {1'b0, bank_q} + {1'b0, page_q};
  assign w_bank_nxt = {1'b0, bank_q} + w_page_nxt;
  assign w_page_ok  = (w_page_nxt < PAGES4) && (w_bank_nxt <= 4'd5);
  assign w_col_nxt  = col_q + 8'd1;
  assign w_xc_nxt   = {1'b0, x_q} + w_col_nxt;
  assign w_col_ok   = (w_col_nxt < W8) && (w_xc_nxt <= 8'd83);

  always_comb begin
    case (mode_q)
      2'd1:    w_byte = 8'h00;
      2'd2:    w_byte = ~bus.rom_data;
      default: w_byte = bus.rom_data;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    init_idx_d = init_idx_q;
    clr_cnt_d  = clr_cnt_q;
    page_d     = page_q;
    col_d      = col_q;
    x_d        = x_q;
    bank_d     = bank_q;
    sel_d      = sel_q;
    mode_d     = mode_q;
    loaded_d   = loaded_q;
    tx_data_d  = tx_data_q;
    tx_dc_d    = tx_dc_q;
    tx_start_d = 1'b1;
    rom_addr_d = rom_addr_q;
    ready_d    = ready_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    back_d     = back_q;

    unique case (state_q)
      S_INIT_CMD: begin
        // first post-reset cycle only loads the opening command
        if (!tx_start_q) begin
          tx_data_d = init_cmd(2'd0);
          tx_dc_d   = 1'b0;
        end else if (bus.tx_avail) begin
          if (init_idx_q == 2'd3) begin
            state_d   = S_CLR_SETX;
            tx_data_d = 8'h80;
          end else begin
            init_idx_d = init_idx_q + 2'd1;
            tx_data_d  = init_cmd(init_idx_q + 2'd1);
          end
        end
      end
      S_CLR_SETX: begin
        if (bus.tx_avail) begin
          state_d   = S_CLR_SETY;
          tx_data_d = 8'h40;
        end
      end
      S_CLR_SETY: begin
        if (bus.tx_avail) begin
          state_d   = S_CLR_DATA;
          tx_data_d = 8'h00;
          tx_dc_d   = 1'b1;
          clr_cnt_d = 9'd0;
        end
      end
      S_CLR_DATA: begin
        if (bus.tx_avail) begin
          if (clr_cnt_q == 9'd503) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
            back_d  = 1'b1;
          end else begin
            clr_cnt_d = clr_cnt_q + 9'd1;
          end
        end
      end
      S_IDLE: begin
        if (bus.draw_req) begin
          if ((bus.draw_x > 7'd83) || (bus.draw_bank > 3'd5)) begin
            err_d = 1'b1;
          end else begin
            x_d       = bus.draw_x;
            bank_d    = bus.draw_bank;
            sel_d     = bus.draw_sel;
            mode_d    = bus.draw_mode;
            page_d    = 3'd0;
            ready_d   = 1'b0;
            state_d   = S_DRW_SETX;
            tx_data_d = {1'b1, bus.draw_x};
            tx_dc_d   = 1'b0;
          end
        end
      end
      S_DRW_SETX: begin
        if (bus.tx_avail) begin
          state_d   = S_DRW_SETY;
          tx_data_d = {4'h4, w_bank_cur};
        end
      end
      S_DRW_SETY: begin
        if (bus.tx_avail) begin
          state_d    = S_DRW_FETCH;
          col_d      = 8'd0;
          rom_addr_d = addr_of(sel_q, page_q, 8'd0);
          loaded_d   = 1'b0;
        end
      end
      S_DRW_FETCH: begin
        state_d  = S_DRW_DATA;
        loaded_d = 1'b0;
      end
      S_DRW_DATA: begin
        // rom_data is valid on entry; tx_avail only counts once the byte is loaded
        if (!loaded_q) begin
          tx_data_d = w_byte;
          tx_dc_d   = 1'b1;
          loaded_d  = 1'b1;
        end else if (bus.tx_avail) begin
          if (w_col_ok) begin
            col_d      = w_col_nxt;
            rom_addr_d = addr_of(sel_q, page_q, w_col_nxt);
            loaded_d   = 1'b0;
            state_d    = S_DRW_FETCH;
          end else if (w_page_ok) begin
            page_d    = w_page_nxt[2:0];
            state_d   = S_DRW_SETX;
            tx_data_d = {1'b1, x_q};
            tx_dc_d   = 1'b0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ready_d = 1'b1;
      end
      default: begin
        state_d = S_INIT_CMD;
      end
    endcase
  end

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q    <= S_INIT_CMD;
      init_idx_q <= 2'd0;
      clr_cnt_q  <= 9'd0;
      page_q     <= 3'd0;
      col_q      <= 8'd0;
      x_q        <= 7'd0;
      bank_q     <= 3'd0;
      sel_q      <= '0;
      mode_q     <= 2'd0;
      loaded_q   <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_dc_q    <= 1'b0;
      tx_start_q <= 1'b0;
      rom_addr_q <= '0;
      ready_q    <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      back_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_idx_q <= init_idx_d;
      clr_cnt_q  <= clr_cnt_d;
      page_q     <= page_d;
      col_q      <= col_d;
      x_q        <= x_d;
      bank_q     <= bank_d;
      sel_q      <= sel_d;
      mode_q     <= mode_d;
      loaded_q   <= loaded_d;
      tx_data_q  <= tx_data_d;
      tx_dc_q    <= tx_dc_d;
      tx_start_q <= tx_start_d;
      rom_addr_q <= rom_addr_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      back_q     <= back_d;
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_dc    = tx_dc_q;
  assign bus.tx_start = tx_start_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.ready    = ready_q;
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.back     = back_q;
endmodule
`default_nettype wire

// File: tb/tb_pcd8544_sprite_seq.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_pcd8544_sprite_seq : scoreboard bench with a 4-cycle spi_master model
// Rev 1.0
// ------------------------------------------------------------------
module tb_pcd8544_sprite_seq;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pcd8544_sprite_seq_if #(.SEL_W(2), .ROM_AW(8)) bus ();

  pcd8544_sprite_seq dut (
    .clock (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  logic [7:0] rom [256];
  logic [8:0] exp_q [$];
  logic [8:0] obs_q [$];
  event       obs_ev;
  int         checks   = 0;
  int         errors   = 0;
  int         consumed = 0;
  int         gap      = 3;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 8'(i);
  end

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  // spi_master stand-in: consumes the presented byte at most every 4 cycles
  always @(negedge clk) begin
    if (!rst_n) begin
      bus.tx_avail = 1'b0;
      gap = 3;
    end else begin
      bus.tx_avail = 1'b0;
      if (gap != 0) begin
        gap--;
      end else if (bus.tx_start && !bus.ready && !bus.done && !bus.err) begin
        bus.tx_avail = 1'b1;
        obs_q.push_back({bus.tx_dc, bus.tx_data});
        gap = 3;
        -> obs_ev;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  initial begin
    logic [8:0] o;
    logic [8:0] e;
    forever begin
      @(obs_ev);
      while (obs_q.size() != 0) begin
        o = obs_q.pop_front();
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte actual=%0h required=none", o);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 32'(o), 32'(e));
        end
        consumed++;
      end
    end
  end

  task automatic push_cmd(input logic [7:0] b);
    exp_q.push_back({1'b0, b});
  endtask

  task automatic push_dat(input logic [7:0] b);
    exp_q.push_back({1'b1, b});
  endtask

  task automatic push_init();
    push_cmd(8'h21); push_cmd(8'h90); push_cmd(8'h20); push_cmd(8'h0C);
    push_cmd(8'h80); push_cmd(8'h40);
    for (int i = 0; i < 504; i++) push_dat(8'h00);
  endtask

  task automatic req(input logic [6:0] x, input logic [2:0] bank,
                     input logic [1:0] sel, input logic [1:0] mode);
    @(negedge clk);
    bus.draw_x    = x;
    bus.draw_bank = bank;
    bus.draw_sel  = sel;
    bus.draw_mode = mode;
    bus.draw_req  = 1'b1;
    @(negedge clk);
    bus.draw_req  = 1'b0;
  endtask

  task automatic wait_ready(input int limit);
    int n = 0;
    while (!bus.ready && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("ready_reached", 32'(bus.ready), 32'd1);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (!bus.done && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("done_pulse", 32'(bus.done), 32'd1);
    check("ready_low_with_done", 32'(bus.ready), 32'd0);
    @(negedge clk);
    check("done_one_cycle", 32'(bus.done), 32'd0);
    check("ready_after_done", 32'(bus.ready), 32'd1);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_tx_data"}, 32'(bus.tx_data), 32'd0);
    check({tag, "_ctl"}, 32'({bus.tx_dc, bus.tx_start, bus.ready, bus.done, bus.err, bus.back}), 32'd0);
    check({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'd0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    bus.draw_req  = 1'b0;
    bus.draw_x    = 7'd0;
    bus.draw_bank = 3'd0;
    bus.draw_sel  = 2'd0;
    bus.draw_mode = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");

    // init + clear
    push_init();
    rst_n = 1'b1;
    wait_ready(4000);
    check("init_drained", 32'(exp_q.size()), 32'd0);
    check("idle_back", 32'(bus.back), 32'd1);

    // basic draw, with an ignored request in the middle
    push_cmd(8'h8A); push_cmd(8'h41);
    for (int i = 32; i < 48; i++) push_dat(8'(i));
    push_cmd(8'h8A); push_cmd(8'h42);
    for (int i = 48; i < 64; i++) push_dat(8'(i));
    c0 = consumed;
    req(7'd10, 3'd1, 2'd1, 2'd0);
    check("ready_falls", 32'(bus.ready), 32'd0);
    repeat (20) @(negedge clk);
    req(7'd0, 3'd0, 2'd0, 2'd0);
    wait_done(1000);
    check("basic_count", 32'(consumed - c0), 32'd36);

    // clipped invert draw at the bottom-right corner
    push_cmd(8'hD0); push_cmd(8'h45);
    push_dat(8'hFF); push_dat(8'hFE); push_dat(8'hFD); push_dat(8'hFC);
    c0 = consumed;
    req(7'd80, 3'd5, 2'd0, 2'd2);
    wait_done(500);
    check("clip_count", 32'(consumed - c0), 32'd6);

    // rejects
    c0 = consumed;
    req(7'd90, 3'd0, 2'd0, 2'd0);
    check("err_x", 32'({bus.err, bus.ready}), 32'b11);
    @(negedge clk);
    check("err_x_pulse", 32'({bus.err, bus.ready}), 32'b01);
    req(7'd0, 3'd6, 2'd0, 2'd0);
    check("err_bank", 32'({bus.err, bus.ready}), 32'b11);
    repeat (20) @(negedge clk);
    check("reject_no_bytes", 32'(consumed - c0), 32'd0);

    // erase
    push_cmd(8'h80); push_cmd(8'h40);
    for (int i = 0; i < 16; i++) push_dat(8'h00);
    push_cmd(8'h80); push_cmd(8'h41);
    for (int i = 0; i < 16; i++) push_dat(8'h00);
    req(7'd0, 3'd0, 2'd2, 2'd1);
    wait_done(1000);

    // reset after five data bytes of a draw
    push_cmd(8'h80); push_cmd(8'h40);
    for (int i = 0; i < 5; i++) push_dat(8'(i));
    c0 = consumed;
    req(7'd0, 3'd0, 2'd0, 2'd0);
    begin
      int n = 0;
      while ((consumed - c0) < 7 && n < 500) begin
        @(negedge clk);
        n++;
      end
    end
    check("pre_reset_count", 32'(consumed - c0), 32'd7);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    repeat (3) @(negedge clk);
    push_init();
    rst_n = 1'b1;
    wait_ready(4000);
    check("reinit_drained", 32'(exp_q.size()), 32'd0);

    repeat (10) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
